deser_queue_top: RTL and testbench
==================================

// Module: deser_queue_top
// PURPOSE
//  Serial-to-parallel front end feeding an 8-entry byte FIFO, single clock domain.
//  The deserializer packs 8 serial bits into a byte and offers it with data_ready.
//  The byte enters the queue when the enqueue enable is high and the queue has room.
//  The queue exposes its head byte and occupancy to the downstream consumer.
// PARAMETERS
//  WIDTH  8  byte width; the shift register, queue entries and data_out are this wide
//  DEPTH  8  queue entries; len_out is $clog2(DEPTH)+1 = 4 bits wide
// PORTS
//  clock       in   1  system clock; all state changes on the rising edge
//  reset       in   1  asynchronous active-low reset
//  data_in     in   1  serial data bit; MSB first
//  write_in    in   1  data_in is valid this cycle
//  enqueue_in  in   1  enable: allow the held byte to move into the queue
//  dequeue_in  in   1  pop request for the queue head
//  data_ready  out  1  deserializer holds a complete byte not yet queued
//  status_out  out  1  deserializer busy (holding a byte); serial input is ignored
//  len_out     out  4  number of queued entries, 0..8
//  data_out    out  8  head-of-queue byte; 8'h00 when the queue is empty
// BEHAVIOUR
//  Reset (reset=0, async): shift reg=0, bit count=0, hold reg=0, data_ready=0,
//   status_out=0, queue pointers=0, len_out=0, data_out=0. Outputs stay at reset values while reset=0.
//  Deserializer, when status_out=0:
//   - Each edge with write_in=1 does shift<={shift[6:0],data_in} and cnt++ (3-bit).
//   - write_in=0 does nothing; cnt holds and bits need not be contiguous in time.
//   - On the edge that takes the 8th bit (cnt==7), the complete byte goes to the hold reg.
//     On that same edge cnt<=0, data_ready<=1 and status_out<=1.
//     The byte is visible on the next cycle.
//  Deserializer, when status_out=1: write_in/data_in ignored (bits dropped, cnt unchanged).
//  Transfer into the queue happens on an edge where data_ready=1, enqueue_in=1 and the
//   queue accepts the write. The write is accepted when len_out<8, or when len_out==8
//   and a valid dequeue occurs on the same edge.
//   - On that edge the hold reg is written at the tail, tail++ (wraps 7->0),
//     data_ready<=0 and status_out<=0.
//   - Serial bits are accepted again from the next edge.
//   - If the queue is full, or enqueue_in=0, the byte is held indefinitely; nothing is lost.
//  Dequeue: on an edge with dequeue_in=1 and len_out>0, head++ (wraps 7->0).
//   dequeue_in with len_out==0 is ignored.
//  Occupancy: len_out += enq - deq per edge. A simultaneous enqueue and dequeue leaves
//   len_out unchanged. len_out never exceeds 8 or underflows.
//  data_out = mem[head] when len_out>0, else 0. It is a combinational read of registers,
//   so it updates in the same cycle as head/len change.
//  Latency: 8th bit edge -> data_ready next cycle. Enqueue edge -> len_out/data_out
//   updated next cycle. First byte into an empty queue appears on data_out 1 cycle after enqueue.
//  Reset mid-byte or mid-hold discards the partial/held byte and the queue contents.
// TESTING
//  1. Reset low for 2 cycles -> len_out=0, data_out=0, data_ready=0, status_out=0.
//  2. enqueue_in=0; shift 1,0,1,0,0,1,0,1 with write_in=1 -> data_ready=1, status_out=1,
//     len_out=0. Then enqueue_in=1 -> len_out=1, data_out=8'hA5, data_ready=0.
//  3. Send 9 bytes 8'h01..8'h09 with enqueue_in=1 ->
//     - len_out=8, 9th byte held (data_ready=1).
//     - One dequeue -> 9th byte enters, len_out stays 8, data_out=8'h02.
//  4. While status_out=1, toggle data_in with write_in=1 -> bits dropped; the next byte
//     after release is assembled correctly.
//  5. Wrap-around: 12 pushes interleaved with pops -> FIFO order preserved.
//     dequeue on empty -> len_out stays 0, data_out=0.
//  6. Assert reset after 4 bits shifted and 3 bytes queued -> all outputs 0.
//     The next 8 bits form a fresh byte.

Source files
------------

// File: rtl/deser_queue_top_if.sv
// Handshake/data bundle between the serial producer, the byte queue and the downstream consumer.
interface deser_queue_top_if #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned LEN_W = 4
);
    logic             data_in;
    logic             write_in;
    logic             enqueue_in;
    logic             dequeue_in;
    logic             data_ready;
    logic             status_out;
    logic [LEN_W-1:0] len_out;
    logic [WIDTH-1:0] data_out;

    modport master (
        output data_in, write_in, enqueue_in, dequeue_in,
        input  data_ready, status_out, len_out, data_out
    );

    modport slave (
        input  data_in, write_in, enqueue_in, dequeue_in,
        output data_ready, status_out, len_out, data_out
    );
endinterface

// File: rtl/deser_queue_top.sv
// Serial-to-parallel deserializer (MSB first) feeding a DEPTH-entry byte FIFO.
// A completed byte is held, blocking further serial input, until it is enqueued.
module deser_queue_top #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 8
) (
    input  logic                clock,
    input  logic                reset,
    deser_queue_top_if.slave    bus
);
    localparam int unsigned CNT_W = $clog2(WIDTH);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned LEN_W = PTR_W + 1;

    typedef enum logic {
        ST_COLLECT = 1'b0,
        ST_HOLD    = 1'b1
    } state_t;

    state_t             state;
    state_t             state_next;
    logic               holding_c;

    logic [CNT_W-1:0]   cnt;
    // Only the low WIDTH-1 bits are ever needed; the MSB leaves with the completing bit.
    logic [WIDTH-2:0]   shift;
    logic [WIDTH-1:0]   hold;

    logic [WIDTH-1:0]   mem [DEPTH];
    logic [PTR_W-1:0]   head;
    logic [PTR_W-1:0]   tail;
    logic [LEN_W-1:0]   len;

    logic               write_bit_c;
    logic               last_bit_c;
    logic               do_deq_c;
    logic               do_enq_c;
    logic               full_c;

    assign write_bit_c = (state == ST_COLLECT) && bus.write_in;
    assign last_bit_c  = write_bit_c && (cnt == CNT_W'(WIDTH - 1));
    assign full_c      = (len == LEN_W'(DEPTH));
    assign do_deq_c    = bus.dequeue_in && (len != '0);
    // A full queue still takes the held byte when the head is popped on the same edge.
    assign do_enq_c    = (state == ST_HOLD) && bus.enqueue_in && (!full_c || do_deq_c);

    // State register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= ST_COLLECT;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            ST_COLLECT: if (last_bit_c) state_next = ST_HOLD;
            ST_HOLD:    if (do_enq_c)   state_next = ST_COLLECT;
            default:    state_next = ST_COLLECT;
        endcase
    end

    // Output decode
    always_comb begin
        holding_c = 1'b0;
        case (state)
            ST_HOLD: holding_c = 1'b1;
            default: holding_c = 1'b0;
        endcase
    end

    assign bus.data_ready = holding_c;
    assign bus.status_out = holding_c;

    // Bit collection and byte capture
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt   <= '0;
            shift <= '0;
            hold  <= '0;
        end else if (write_bit_c) begin
            shift <= {shift[WIDTH-3:0], bus.data_in};
            if (last_bit_c) begin
                cnt  <= '0;
                hold <= {shift, bus.data_in};
            end else begin
                cnt  <= cnt + CNT_W'(1);
            end
        end
    end

    // Queue storage; contents are don't-care until covered by len
    always_ff @(posedge clock) begin
        if (do_enq_c) begin
            mem[tail] <= hold;
        end
    end

    // Queue pointers and occupancy
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            head <= '0;
            tail <= '0;
            len  <= '0;
        end else begin
            if (do_enq_c) tail <= tail + PTR_W'(1);
            if (do_deq_c) head <= head + PTR_W'(1);
            case ({do_enq_c, do_deq_c})
                2'b10:   len <= len + LEN_W'(1);
                2'b01:   len <= len - LEN_W'(1);
                default: len <= len;
            endcase
        end
    end

    assign bus.len_out  = len;
    assign bus.data_out = (len != '0) ? mem[head] : '0;
endmodule

// File: tb/tb_deser_queue_top.sv
// Directed self-checking bench for deser_queue_top: hold, full queue, dropped bits, wrap and reset.
module tb_deser_queue_top;
    logic clock;
    logic reset;
    int   total;
    int   bad;

    deser_queue_top_if #(.WIDTH(8), .LEN_W(4)) bus ();

    deser_queue_top #(.WIDTH(8), .DEPTH(8)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic shift_byte(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) begin
            bus.data_in  = b[i];
            bus.write_in = 1'b1;
            step();
        end
        bus.write_in = 1'b0;
    endtask

    // Shift a byte then give one idle edge for the enqueue
    task automatic push_byte(input logic [7:0] b);
        bus.enqueue_in = 1'b1;
        shift_byte(b);
        step();
    endtask

    task automatic pop();
        bus.dequeue_in = 1'b1;
        step();
        bus.dequeue_in = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        step();
        step();
        total++; if (bus.len_out !== 4'd0) begin bad++; $display("FAIL reset_len got=%0d want=0", bus.len_out); end
        total++; if (bus.data_out !== 8'h00) begin bad++; $display("FAIL reset_data got=%h want=00", bus.data_out); end
        total++; if (bus.data_ready !== 1'b0) begin bad++; $display("FAIL reset_ready got=%b want=0", bus.data_ready); end
        total++; if (bus.status_out !== 1'b0) begin bad++; $display("FAIL reset_status got=%b want=0", bus.status_out); end
        reset = 1'b1;
        step();
    endtask

    task automatic test_hold_then_enqueue();
        bus.enqueue_in = 1'b0;
        shift_byte(8'hA5);
        total++; if (bus.data_ready !== 1'b1) begin bad++; $display("FAIL hold_ready got=%b want=1", bus.data_ready); end
        total++; if (bus.status_out !== 1'b1) begin bad++; $display("FAIL hold_status got=%b want=1", bus.status_out); end
        total++; if (bus.len_out !== 4'd0) begin bad++; $display("FAIL hold_len got=%0d want=0", bus.len_out); end
        step();
        step();
        total++; if (bus.data_ready !== 1'b1) begin bad++; $display("FAIL hold_keep got=%b want=1", bus.data_ready); end
        bus.enqueue_in = 1'b1;
        step();
        bus.enqueue_in = 1'b0;
        total++; if (bus.len_out !== 4'd1) begin bad++; $display("FAIL enq_len got=%0d want=1", bus.len_out); end
        total++; if (bus.data_out !== 8'hA5) begin bad++; $display("FAIL enq_data got=%h want=a5", bus.data_out); end
        total++; if (bus.data_ready !== 1'b0) begin bad++; $display("FAIL enq_ready got=%b want=0", bus.data_ready); end
        total++; if (bus.status_out !== 1'b0) begin bad++; $display("FAIL enq_status got=%b want=0", bus.status_out); end
        pop();
        total++; if (bus.len_out !== 4'd0) begin bad++; $display("FAIL pop1_len got=%0d want=0", bus.len_out); end
        total++; if (bus.data_out !== 8'h00) begin bad++; $display("FAIL pop1_data got=%h want=00", bus.data_out); end
    endtask

    task automatic test_full();
        for (int k = 1; k <= 8; k++) begin
            push_byte(8'(k));
            total++; if (bus.len_out !== 4'(k)) begin bad++; $display("FAIL fill_len k=%0d got=%0d want=%0d", k, bus.len_out, k); end
        end
        push_byte(8'h09);
        total++; if (bus.len_out !== 4'd8) begin bad++; $display("FAIL full_len got=%0d want=8", bus.len_out); end
        total++; if (bus.data_ready !== 1'b1) begin bad++; $display("FAIL full_ready got=%b want=1", bus.data_ready); end
        total++; if (bus.data_out !== 8'h01) begin bad++; $display("FAIL full_head got=%h want=01", bus.data_out); end
        pop();
        total++; if (bus.len_out !== 4'd8) begin bad++; $display("FAIL fullpop_len got=%0d want=8", bus.len_out); end
        total++; if (bus.data_out !== 8'h02) begin bad++; $display("FAIL fullpop_head got=%h want=02", bus.data_out); end
        total++; if (bus.data_ready !== 1'b0) begin bad++; $display("FAIL fullpop_ready got=%b want=0", bus.data_ready); end
        for (int k = 2; k <= 9; k++) begin
            total++; if (bus.data_out !== 8'(k)) begin bad++; $display("FAIL drain_data k=%0d got=%h want=%h", k, bus.data_out, 8'(k)); end
            pop();
        end
        total++; if (bus.len_out !== 4'd0) begin bad++; $display("FAIL drain_len got=%0d want=0", bus.len_out); end
        bus.enqueue_in = 1'b0;
    endtask

    task automatic test_drop_while_busy();
        bus.enqueue_in = 1'b0;
        shift_byte(8'h3C);
        for (int i = 0; i < 5; i++) begin
            bus.data_in  = i[0];
            bus.write_in = 1'b1;
            step();
        end
        bus.write_in = 1'b0;
        total++; if (bus.status_out !== 1'b1) begin bad++; $display("FAIL busy_status got=%b want=1", bus.status_out); end
        total++; if (bus.len_out !== 4'd0) begin bad++; $display("FAIL busy_len got=%0d want=0", bus.len_out); end
        bus.enqueue_in = 1'b1;
        step();
        total++; if (bus.data_out !== 8'h3C) begin bad++; $display("FAIL busy_data got=%h want=3c", bus.data_out); end
        push_byte(8'hC3);
        total++; if (bus.len_out !== 4'd2) begin bad++; $display("FAIL next_len got=%0d want=2", bus.len_out); end
        pop();
        total++; if (bus.data_out !== 8'hC3) begin bad++; $display("FAIL next_data got=%h want=c3", bus.data_out); end
        pop();
        bus.enqueue_in = 1'b0;
    endtask

    task automatic test_wrap();
        logic [7:0] exp_q[$];
        logic [7:0] b;
        for (int i = 0; i < 12; i++) begin
            b = 8'h10 + 8'(i);
            push_byte(b);
            exp_q.push_back(b);
            if (i[0]) begin
                total++; if (bus.data_out !== exp_q[0]) begin bad++; $display("FAIL wrap_mid i=%0d got=%h want=%h", i, bus.data_out, exp_q[0]); end
                pop();
                void'(exp_q.pop_front());
            end
        end
        total++; if (bus.len_out !== 4'd6) begin bad++; $display("FAIL wrap_len got=%0d want=6", bus.len_out); end
        while (exp_q.size() > 0) begin
            total++; if (bus.data_out !== exp_q[0]) begin bad++; $display("FAIL wrap_drain got=%h want=%h", bus.data_out, exp_q[0]); end
            pop();
            void'(exp_q.pop_front());
        end
        pop();
        total++; if (bus.len_out !== 4'd0) begin bad++; $display("FAIL empty_pop_len got=%0d want=0", bus.len_out); end
        total++; if (bus.data_out !== 8'h00) begin bad++; $display("FAIL empty_pop_data got=%h want=00", bus.data_out); end
        bus.enqueue_in = 1'b0;
    endtask

    task automatic test_reset_mid();
        push_byte(8'hAA);
        push_byte(8'hBB);
        push_byte(8'hCC);
        total++; if (bus.len_out !== 4'd3) begin bad++; $display("FAIL pre_rst_len got=%0d want=3", bus.len_out); end
        for (int i = 0; i < 4; i++) begin
            bus.data_in  = 1'b1;
            bus.write_in = 1'b1;
            step();
        end
        bus.write_in = 1'b0;
        reset = 1'b0;
        #1;
        total++; if (bus.len_out !== 4'd0) begin bad++; $display("FAIL rst_len got=%0d want=0", bus.len_out); end
        total++; if (bus.data_out !== 8'h00) begin bad++; $display("FAIL rst_data got=%h want=00", bus.data_out); end
        total++; if (bus.data_ready !== 1'b0) begin bad++; $display("FAIL rst_ready got=%b want=0", bus.data_ready); end
        step();
        step();
        reset = 1'b1;
        push_byte(8'h96);
        total++; if (bus.len_out !== 4'd1) begin bad++; $display("FAIL fresh_len got=%0d want=1", bus.len_out); end
        total++; if (bus.data_out !== 8'h96) begin bad++; $display("FAIL fresh_data got=%h want=96", bus.data_out); end
        bus.enqueue_in = 1'b0;
    endtask

    initial begin
        total          = 0;
        bad            = 0;
        reset          = 1'b0;
        bus.data_in    = 1'b0;
        bus.write_in   = 1'b0;
        bus.enqueue_in = 1'b0;
        bus.dequeue_in = 1'b0;
        test_reset();
        test_hold_then_enqueue();
        test_full();
        test_drop_while_busy();
        test_wrap();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
